// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
//   Shared definitions for the serial arithmetic blocks.
//   - State encoding for the IDLE/BUSY/DONE handshake controller.
//   - cnt_width(): width of a bit counter that must reach width-1.
// -----------------------------------------------------------------------------
package arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_e;

    // Counter width able to hold 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage : arith_pkg

// File: rtl/full_subtractor1.sv
// -----------------------------------------------------------------------------
// full_subtractor1
//   One-bit full subtractor: Ai - Bi - Ci.
//   Ports:
//     Ai  in   minuend bit
//     Bi  in   subtrahend bit
//     Ci  in   borrow in
//     Do  out  difference bit
//     Co  out  borrow out
//   Purely combinational.
// -----------------------------------------------------------------------------
module full_subtractor1 (
    input  logic Ai,
    input  logic Bi,
    input  logic Ci,
    output logic Do,
    output logic Co
);

    assign Do = Ai ^ Bi ^ Ci;
    // Borrow when the minuend bit is 0 and the subtrahend bit is 1, or when
    // the two bits are equal and a borrow is already pending.
    assign Co = (~Ai & Bi) | (~(Ai ^ Bi) & Ci);

endmodule : full_subtractor1

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor: {bo, d} = a - b - bi, LSB first,
//   one bit per clock through a single full_subtractor1 cell.
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   synchronous reset, active-high
//     in_valid   in   a/b/bi are valid
//     in_ready   out  block can accept operands (IDLE and not in reset)
//     a, b       in   WIDTH-bit minuend / subtrahend
//     bi         in   input borrow
//     out_valid  out  d/bo are valid
//     out_ready  in   consumer accepts result
//     d          out  difference, a - b - bi mod 2^WIDTH
//     bo         out  borrow out of the MSB cell
//   Latency: out_valid rises WIDTH edges after the accept edge.
// -----------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be at least 2");
    end

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] d_q,         d_d;
    logic             borrow_q,    borrow_d;
    logic             bo_q,        bo_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    cnt_q,       cnt_d;

    logic             fs_diff;
    logic             fs_borrow;

    full_subtractor1 u_fs (
        .Ai (a_q[0]),
        .Bi (b_q[0]),
        .Ci (borrow_q),
        .Do (fs_diff),
        .Co (fs_borrow)
    );

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bo        = bo_q;

    // NOTE: every *_d gets its hold value first so no path leaves it
    // unassigned; otherwise always_comb would infer a latch.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        d_d         = d_q;
        borrow_d    = borrow_q;
        bo_d        = bo_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bi;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end

            BUSY: begin
                // Difference bits enter at the MSB so that after WIDTH shifts
                // the first (LSB) result bit has reached position 0.
                d_d      = {fs_diff, d_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = fs_borrow;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // bo is kept apart from the running borrow so it stays
                    // stable in DONE and after the handshake.
                    bo_d        = fs_borrow;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; reset is synchronous, so it is only seen on clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            bo_q        <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            d_q         <= d_d;
            borrow_q    <= borrow_d;
            bo_q        <= bo_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed and shuffled-exhaustive checks of serial_subtractor (WIDTH=4)
//   against plain integer arithmetic a - b - bi.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] d;
    logic       bo;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later, away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("wait_in_ready", 32'(in_ready), 32'd1);
    endtask

    // One full transaction; hold = cycles of out_ready=0 after out_valid.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb,
                          input logic tbi, input int hold, input string tag);
        int         full;
        int         n;
        logic [3:0] exp_d;
        logic       exp_bo;
        full   = int'(ta) - int'(tb) - int'(tbi);
        exp_d  = 4'(full);
        exp_bo = (full < 0);

        wait_ready();
        a         = ta;
        b         = tb;
        bi        = tbi;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        step();
        in_valid = 1'b0;

        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 20);
        check({tag, "_latency"}, 32'(n), 32'd4);
        check({tag, "_d"},  32'(d),  32'(exp_d));
        check({tag, "_bo"}, 32'(bo), 32'(exp_bo));

        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_d"},     32'(d),         32'(exp_d));
            check({tag, "_hold_bo"},    32'(bo),        32'(exp_bo));
            check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        step();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int order [512];
        int tmp;
        int j;
        int idx;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bi        = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d",         32'(d),         32'd0);
        check("rst_bo",        32'(bo),        32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed arithmetic cases
        run_op(4'd9, 4'd3, 1'b0, 0, "9m3");
        run_op(4'd3, 4'd9, 1'b0, 0, "3m9");
        run_op(4'h0, 4'h0, 1'b1, 0, "0m0b");
        run_op(4'hF, 4'hF, 1'b1, 0, "FmFb");

        // Back-pressure: out_ready low for 5 cycles after out_valid
        run_op(4'd11, 4'd2, 1'b1, 5, "bp");

        // in_valid toggling with new operands while 12 - 5 is in flight
        wait_ready();
        a         = 4'd12;
        b         = 4'd5;
        bi        = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        a        = 4'd1;
        b        = 4'd1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = ~in_valid;
            step();
            check("tog_busy_ready", 32'(in_ready), 32'd0);
        end
        check("tog_valid", 32'(out_valid), 32'd1);
        check("tog_d",     32'(d),         32'd7);
        check("tog_bo",    32'(bo),        32'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check("tog_valid_drop", 32'(out_valid), 32'd0);
        check("tog_idle_ready", 32'(in_ready),  32'd1);
        step();
        check("tog_second_accept", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (4) step();
        check("tog2_valid", 32'(out_valid), 32'd1);
        check("tog2_d",     32'(d),         32'd0);
        check("tog2_bo",    32'(bo),        32'd0);
        out_ready = 1'b1;
        step();
        check("tog2_valid_drop", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset in the second BUSY cycle aborts the operation
        wait_ready();
        a        = 4'd9;
        b        = 4'd3;
        bi       = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_d",         32'(d),         32'd0);
        check("abort_bo",        32'(bo),        32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_op(4'd8, 4'd1, 1'b0, 0, "8m1");

        // All 512 (a, b, bi) combinations in shuffled order, random hold
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 512; i++) begin
            idx = order[i];
            run_op(idx[3:0], idx[7:4], idx[8], int'($urandom_range(2, 0)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_subtractor
